// File: rtl/sync_supervisor_pkg.sv
// Shared definitions for the PCS sync supervisor: state encodings,
// default timing constants and the effective signal-detect helper.
package sync_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_HOLD     = 3'd1,
        ST_WAIT_SIG = 3'd2,
        ST_ACQUIRE  = 3'd3,
        ST_QUALIFY  = 3'd4,
        ST_LINK_UP  = 3'd5
    } state_t;

    localparam int DEF_HOLD_CYC    = 4;
    localparam int DEF_ACQ_TIMEOUT = 1024;
    localparam int DEF_LINK_QUAL   = 64;
    localparam int DEF_TMR_W       = 16;
    localparam int DEF_CNT_W       = 8;

    // Loopback makes the receive path look healthy regardless of the PMA.
    function automatic logic sig_effective(input logic signal_detect,
                                           input logic loopback);
        return signal_detect | loopback;
    endfunction

endpackage

// File: rtl/sync_supervisor_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count events, stick at all-ones, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/sync_supervisor.sv
// Link-level sequencer for the 1000BASE-X PCS synchronization block:
// powers and resets the sync block, times acquisition with retry,
// debounces CODE_SYNC into LINK_OK and keeps loss-of-sync statistics.
module sync_supervisor
    import sync_supervisor_pkg::*;
#(
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int ACQ_TIMEOUT = DEF_ACQ_TIMEOUT,
    parameter int LINK_QUAL   = DEF_LINK_QUAL,
    parameter int TMR_W       = DEF_TMR_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             SIGNAL_DETECT,
    input  logic             MR_LOOPBACK,
    input  logic             CODE_SYNC,
    input  logic             CLR_STATS,
    output logic             SYNC_POWER,
    output logic             SYNC_RESET,
    output logic             SIGNAL_CHANGE,
    output logic             LINK_OK,
    output logic [CNT_W-1:0] LOS_COUNT,
    output logic [CNT_W-1:0] ACQ_FAIL_CNT,
    output logic             ACQ_FAIL,
    output logic [2:0]       STATE
);

    // Terminal timer values: the timer starts at 0 on entry, so the last
    // cycle of an N-cycle window sees N-1.
    localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST  = TMR_W'(ACQ_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] QUAL_LAST = TMR_W'(LINK_QUAL - 1);

    logic             sig_ok_s;
    logic             sig_q_r;
    logic             change_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic             los_inc_s;
    logic             acq_inc_s;
    logic             acq_fail_r;
    logic             power_r;
    logic             sreset_r;
    logic             link_r;

    assign sig_ok_s = sig_effective(SIGNAL_DETECT, MR_LOOPBACK);

    // Next-state, timer and statistics-event logic; ENABLE overrides all.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        los_inc_s   = 1'b0;
        acq_inc_s   = 1'b0;
        if (!ENABLE) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_HOLD;
                    timer_nxt_s = '0;
                end
                ST_HOLD: begin
                    if (timer_r == HOLD_LAST) begin
                        state_nxt_s = ST_WAIT_SIG;
                    end else begin
                        timer_nxt_s = timer_r + TMR_ONE;
                    end
                end
                ST_WAIT_SIG: begin
                    if (sig_ok_s) begin
                        state_nxt_s = ST_ACQUIRE;
                        timer_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_WAIT_SIG;
                    end
                end
                ST_ACQUIRE: begin
                    if (!sig_ok_s) begin
                        state_nxt_s = ST_WAIT_SIG;
                    end else if (CODE_SYNC) begin
                        state_nxt_s = ST_QUALIFY;
                        timer_nxt_s = '0;
                    end else if (timer_r == ACQ_LAST) begin
                        state_nxt_s = ST_HOLD;
                        timer_nxt_s = '0;
                        acq_inc_s   = 1'b1;
                    end else begin
                        timer_nxt_s = timer_r + TMR_ONE;
                    end
                end
                ST_QUALIFY: begin
                    if (!sig_ok_s) begin
                        state_nxt_s = ST_WAIT_SIG;
                    end else if (!CODE_SYNC) begin
                        state_nxt_s = ST_ACQUIRE;
                        timer_nxt_s = '0;
                    end else if (timer_r == QUAL_LAST) begin
                        state_nxt_s = ST_LINK_UP;
                    end else begin
                        timer_nxt_s = timer_r + TMR_ONE;
                    end
                end
                ST_LINK_UP: begin
                    if (!sig_ok_s) begin
                        state_nxt_s = ST_WAIT_SIG;
                        los_inc_s   = 1'b1;
                    end else if (!CODE_SYNC) begin
                        state_nxt_s = ST_ACQUIRE;
                        timer_nxt_s = '0;
                        los_inc_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_LINK_UP;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    timer_nxt_s = '0;
                end
            endcase
        end
    end

    // State register with outputs decoded from the state being entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= ST_OFF;
            timer_r  <= '0;
            power_r  <= 1'b0;
            sreset_r <= 1'b1;
            link_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            power_r  <= (state_nxt_s != ST_OFF);
            sreset_r <= (state_nxt_s == ST_OFF) || (state_nxt_s == ST_HOLD);
            link_r   <= (state_nxt_s == ST_LINK_UP);
        end
    end

    // Edge detector on the effective signal, active in every state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sig_q_r  <= 1'b0;
            change_r <= 1'b0;
        end else begin
            sig_q_r  <= sig_ok_s;
            change_r <= (sig_ok_s != sig_q_r);
        end
    end

    // Sticky acquisition-failure flag; clear beats a simultaneous timeout.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acq_fail_r <= 1'b0;
        end else if (CLR_STATS) begin
            acq_fail_r <= 1'b0;
        end else if (acq_inc_s) begin
            acq_fail_r <= 1'b1;
        end else begin
            acq_fail_r <= acq_fail_r;
        end
    end

    sat_counter #(.W(CNT_W)) u_los_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (los_inc_s),
        .clr   (CLR_STATS),
        .count (LOS_COUNT)
    );

    sat_counter #(.W(CNT_W)) u_acq_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (acq_inc_s),
        .clr   (CLR_STATS),
        .count (ACQ_FAIL_CNT)
    );

    assign SYNC_POWER    = power_r;
    assign SYNC_RESET    = sreset_r;
    assign SIGNAL_CHANGE = change_r;
    assign LINK_OK       = link_r;
    assign ACQ_FAIL      = acq_fail_r;
    assign STATE         = state_r;

endmodule
